// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state codes, panel geometry and default sequencing times for the LCD path
package lcd_pkg;
  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_PWR_UP   = 3'd1,
    S_RST_REL  = 3'd2,
    S_WAIT_FRM = 3'd3,
    S_ON       = 3'd4,
    S_BL_OFF   = 3'd5,
    S_PWR_DN   = 3'd6,
    S_FLT      = 3'd7
  } lcd_state_e;
  localparam int H_ACTIVE = 480;
  localparam int V_ACTIVE = 272;
  localparam int H_FP = 2;
  localparam int H_PULSE = 41;
  localparam int H_BP = 2;
  localparam int V_FP = 2;
  localparam int V_PULSE = 10;
  localparam int V_BP = 2;
  localparam int unsigned T_PWR_CYC_DEF = 1000;
  localparam int unsigned T_RST_CYC_DEF = 500;
  localparam int unsigned FRAMES_BEFORE_BL_DEF = 2;
  localparam int unsigned BL_DUTY_DEF = 200;
  localparam int unsigned T_OFF_CYC_DEF = 1000;
  localparam int unsigned VS_TIMEOUT_CYC_DEF = 200000;
  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/lcd_power_sequencer_if.sv
// lcd_power_sequencer_if: panel power request, vsync and sequenced panel controls
interface lcd_power_sequencer_if;
  logic PWR_REQ;
  logic LCD_VSYNC;
  logic LCD_PWR_EN;
  logic LCD_RST_N;
  logic TIMING_nRST;
  logic LCD_BL_PWM;
  logic READY;
  logic FAULT;
  logic [2:0] STATE;
  modport master(output PWR_REQ, LCD_VSYNC,
                 input LCD_PWR_EN, LCD_RST_N, TIMING_nRST, LCD_BL_PWM, READY, FAULT, STATE);
  modport slave(input PWR_REQ, LCD_VSYNC,
                output LCD_PWR_EN, LCD_RST_N, TIMING_nRST, LCD_BL_PWM, READY, FAULT, STATE);
endinterface

// File: rtl/lcd_bl_pwm.sv
// lcd_bl_pwm: 8-bit backlight PWM with optional duty fade-in (LCD_BL_FADE_EN)
module lcd_bl_pwm (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       en,
  input  logic [7:0] target,
  output logic       pwm,
  output logic       at_target
);
  logic [7:0] pwm_cnt;
  logic [7:0] duty;
`ifdef LCD_BL_FADE_EN
  // ramp duty by one step per PWM period until it reaches the target
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      pwm_cnt <= '0;
      duty <= '0;
      pwm <= 1'b0;
    end else if (!en) begin
      pwm_cnt <= '0;
      duty <= '0;
      pwm <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      duty <= (pwm_cnt == 8'hff && duty < target) ? duty + 1'b1 : duty;
      pwm <= pwm_cnt < duty;
    end
  assign at_target = duty == target;
`else
  assign duty = en ? target : '0;
  // full duty from the first enabled cycle
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      pwm_cnt <= '0;
      pwm <= 1'b0;
    end else begin
      pwm_cnt <= en ? pwm_cnt + 1'b1 : '0;
      pwm <= en && pwm_cnt < duty;
    end
  assign at_target = 1'b1;
`endif
endmodule

// File: rtl/lcd_power_sequencer.sv
// lcd_power_sequencer: panel supply/reset/timing bring-up, backlight enable and vsync watchdog (LCD_BL_FADE_EN selects backlight fade-in)
module lcd_power_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWR_CYC = T_PWR_CYC_DEF,
  parameter int unsigned T_RST_CYC = T_RST_CYC_DEF,
  parameter int unsigned FRAMES_BEFORE_BL = FRAMES_BEFORE_BL_DEF,
  parameter int unsigned BL_DUTY = BL_DUTY_DEF,
  parameter int unsigned T_OFF_CYC = T_OFF_CYC_DEF,
  parameter int unsigned VS_TIMEOUT_CYC = VS_TIMEOUT_CYC_DEF
) (
  input logic CLK,
  input logic nRST,
  lcd_power_sequencer_if.slave bus
);
  localparam int unsigned DW = $clog2(max3(T_PWR_CYC, T_RST_CYC, T_OFF_CYC) + 1);
  localparam int unsigned TW = $clog2(VS_TIMEOUT_CYC + 1);
  lcd_state_e state;
  logic [DW-1:0] dw_cnt;
  logic [3:0] frm_cnt;
  logic [TW-1:0] to_cnt;
  logic vs_q, vs_fall, live, to_hit, frm_done, bl_en, at_target;
  assign vs_fall = vs_q & ~bus.LCD_VSYNC;
  assign live = state == S_WAIT_FRM || state == S_ON;
  assign to_hit = live && to_cnt == TW'(VS_TIMEOUT_CYC - 1);
  assign frm_done = vs_fall && frm_cnt == 4'(FRAMES_BEFORE_BL - 1);
  assign bl_en = state == S_ON;
  assign bus.STATE = state;
  // sequencing FSM; dwell counter restarts on every state change, fault wins over power-down
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state <= S_OFF;
      dw_cnt <= '0;
      bus.FAULT <= 1'b0;
    end else begin
      dw_cnt <= dw_cnt + 1'b1;
      case (state)
        S_OFF: if (bus.PWR_REQ) begin
          state <= S_PWR_UP;
          dw_cnt <= '0;
          bus.FAULT <= 1'b0;
        end
        S_PWR_UP: if (!bus.PWR_REQ || dw_cnt == DW'(T_PWR_CYC - 1)) begin
          state <= bus.PWR_REQ ? S_RST_REL : S_PWR_DN;
          dw_cnt <= '0;
        end
        S_RST_REL: if (!bus.PWR_REQ || dw_cnt == DW'(T_RST_CYC - 1)) begin
          state <= bus.PWR_REQ ? S_WAIT_FRM : S_PWR_DN;
          dw_cnt <= '0;
        end
        S_WAIT_FRM, S_ON: if (to_hit || !bus.PWR_REQ || (state == S_WAIT_FRM && frm_done)) begin
          state <= to_hit ? S_FLT : !bus.PWR_REQ ? S_BL_OFF : S_ON;
          dw_cnt <= '0;
          bus.FAULT <= to_hit;
        end
        S_BL_OFF: if (dw_cnt == DW'(T_OFF_CYC - 1)) begin
          state <= S_PWR_DN;
          dw_cnt <= '0;
        end
        S_PWR_DN: if (dw_cnt == DW'(T_OFF_CYC - 1)) begin
          state <= S_OFF;
          dw_cnt <= '0;
        end
        S_FLT: if (!bus.PWR_REQ) begin
          state <= S_OFF;
          dw_cnt <= '0;
        end
        default: state <= S_OFF;
      endcase
    end
  // vsync edge detect, frame count in WAIT_FRM and vsync watchdog while the panel is live
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      vs_q <= 1'b0;
      frm_cnt <= '0;
      to_cnt <= '0;
    end else begin
      vs_q <= bus.LCD_VSYNC;
      frm_cnt <= state == S_WAIT_FRM ? frm_cnt + {3'b0, vs_fall} : '0;
      to_cnt <= live && !vs_fall ? to_cnt + 1'b1 : '0;
    end
  // registered output decode, one cycle behind the state
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      bus.LCD_PWR_EN <= 1'b0;
      bus.LCD_RST_N <= 1'b0;
      bus.TIMING_nRST <= 1'b0;
      bus.READY <= 1'b0;
    end else begin
      bus.LCD_PWR_EN <= state inside {[S_PWR_UP:S_BL_OFF]};
      bus.LCD_RST_N <= state inside {[S_RST_REL:S_BL_OFF]};
      bus.TIMING_nRST <= state inside {[S_WAIT_FRM:S_BL_OFF]};
      bus.READY <= bl_en && at_target;
    end
  lcd_bl_pwm u_bl_pwm (
    .CLK(CLK),
    .nRST(nRST),
    .en(bl_en),
    .target(8'(BL_DUTY)),
    .pwm(bus.LCD_BL_PWM),
    .at_target(at_target)
  );
endmodule
